serial_to_parallel: RTL and testbench

Receive-side deserializer that turns the 1-bit line stream into the byte-wide `data_in_c`/`valid_in_c` pair consumed by the 1-to-2 demux. It locks byte alignment on a repeated comma character, declares the link active, then delivers one byte per 8 bit times. The byte cadence matches the demux's clk2f domain. Idle commas are suppressed as `valid_out_c = 0`.

---
 rtl/phy_pkg.sv | 7 +
 rtl/serial_to_parallel_byte_shifter.sv | 27 ++
 rtl/serial_to_parallel.sv | 67 ++++++
 tb/tb_serial_to_parallel.sv | 138 +++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// phy_pkg: constants and link-state encoding shared by the serializer,
// the deserializer and the demux.
package phy_pkg;
   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;
   typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2} link_state_t;
endpackage

// File: rtl/serial_to_parallel_byte_shifter.sv
// byte_shifter: serial-in shift register with a 3-bit byte phase counter.
// realign makes the current edge a byte boundary.
module byte_shifter
   import phy_pkg::*;
(
   input  logic              clk16f,
   input  logic              reset,
   input  logic              data_in_s,
   input  logic              realign,
   output logic              byte_done,
   output logic [BYTE_W-1:0] byte_val
);
   // The oldest bit is never part of a candidate, so only seven are kept.
   logic [BYTE_W-2:0] sr;
   logic [2:0]        bit_cnt;
   always_ff @(posedge clk16f) begin
      if (reset) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else begin
         sr      <= byte_val[BYTE_W-2:0];
         bit_cnt <= realign ? 3'd0 : bit_cnt + 3'd1;
      end
   end
   assign byte_val  = {sr, data_in_s};
   assign byte_done = bit_cnt == 3'd7;
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: comma-aligned 1-bit to byte deserializer; idle commas
// are delivered as valid_out_c = 0 once the link is active.
module serial_to_parallel
   import phy_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
   parameter int                SYNC_COUNT = 4
) (
   input  logic              clk16f,
   input  logic              reset,
   input  logic              data_in_s,
   output logic [BYTE_W-1:0] data_out_c,
   output logic              valid_out_c,
   output logic              active_out
);
   link_state_t       state_q, state_d;
   logic [3:0]        bc_cnt, bc_d;
   logic [BYTE_W-1:0] data_d, byte_val;
   logic              valid_d, realign, byte_done, is_comma;
   byte_shifter u_shifter (
      .clk16f   (clk16f),
      .reset    (reset),
      .data_in_s(data_in_s),
      .realign  (realign),
      .byte_done(byte_done),
      .byte_val (byte_val)
   );
   always_comb begin
      state_d  = state_q;
      bc_d     = bc_cnt;
      data_d   = data_out_c;
      valid_d  = valid_out_c;
      realign  = 1'b0;
      is_comma = byte_val == COMMA;
      case (state_q)
         SEARCH: if (is_comma) begin
            state_d = ALIGN;
            bc_d    = 4'd1;
            realign = 1'b1;
         end
         ALIGN: if (byte_done) begin
            bc_d    = is_comma ? bc_cnt + 4'd1 : 4'd0;
            state_d = !is_comma ? SEARCH : (bc_cnt + 4'd1 == 4'(SYNC_COUNT)) ? ACTIVE : ALIGN;
         end
         ACTIVE: if (byte_done) begin
            data_d  = is_comma ? '0 : byte_val;
            valid_d = !is_comma;
         end
         default: state_d = SEARCH;
      endcase
   end
   always_ff @(posedge clk16f) begin
      if (reset) begin
         state_q     <= SEARCH;
         bc_cnt      <= '0;
         data_out_c  <= '0;
         valid_out_c <= 1'b0;
         active_out  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bc_cnt      <= bc_d;
         data_out_c  <= data_d;
         valid_out_c <= valid_d;
         active_out  <= state_d == ACTIVE;
      end
   end
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed plus random byte streams, every edge
// compared against a bit-history reference model.
module tb_serial_to_parallel;
   localparam logic [7:0] BC = 8'hBC;
   localparam int SYNC = 4;
   logic       clk16f = 1'b0;
   logic       reset = 1'b1;
   logic       data_in_s = 1'b0;
   logic [7:0] data_out_c;
   logic       valid_out_c, active_out;
   int errors = 0;
   int checks = 0;
   int n_edge = 0;
   // Reference model: mode 0 hunting, 1 counting commas, 2 locked.
   int         mode, since;
   logic [7:0] win, m_data;
   logic       m_valid, m_active;
   serial_to_parallel #(.COMMA(BC), .SYNC_COUNT(SYNC)) dut (
      .clk16f     (clk16f),
      .reset      (reset),
      .data_in_s  (data_in_s),
      .data_out_c (data_out_c),
      .valid_out_c(valid_out_c),
      .active_out (active_out)
   );
   always #5 clk16f = ~clk16f;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n_edge, got, exp);
      end
   endtask
   task automatic model_step(input logic r, input logic b);
      if (r) begin
         mode = 0; since = 0; win = '0;
         m_data = '0; m_valid = 1'b0; m_active = 1'b0;
         return;
      end
      win = {win[6:0], b};
      if (mode == 0) begin
         if (win == BC) begin mode = 1; since = 0; end
      end else begin
         since++;
         if (since % 8 == 0) begin
            if (mode == 1) begin
               if (win != BC) mode = 0;
               else if (since / 8 + 1 == SYNC) begin mode = 2; m_active = 1'b1; end
            end else begin
               m_valid = win != BC;
               m_data  = m_valid ? win : 8'h00;
            end
         end
      end
   endtask
   task automatic tick(input logic b, input logic r);
      @(negedge clk16f);
      data_in_s = b;
      reset = r;
      @(posedge clk16f);
      n_edge++;
      model_step(r, b);
      #1;
      chk("data_model", data_out_c, m_data);
      chk("valid_model", {7'd0, valid_out_c}, {7'd0, m_valid});
      chk("active_model", {7'd0, active_out}, {7'd0, m_active});
   endtask
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tick(v[i], 1'b0);
   endtask
   task automatic send_byte(input logic [7:0] v);
      send_bits(v, 8);
   endtask
   task automatic do_reset();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      n_edge = 0;
   endtask
   initial begin
      logic [7:0] rb;
      do_reset();
      chk("reset_data", data_out_c, 8'h00);
      chk("reset_valid", {7'd0, valid_out_c}, 8'h00);
      chk("reset_active", {7'd0, active_out}, 8'h00);
      // Clean lock: active must rise exactly on edge 32.
      for (int i = 0; i < 3; i++) send_byte(BC);
      send_bits(BC >> 1, 7);
      chk("lock_edge31_active", {7'd0, active_out}, 8'h00);
      send_bits(8'h00, 1);
      chk("lock_edge32_active", {7'd0, active_out}, 8'h01);
      chk("lock_valid", {7'd0, valid_out_c}, 8'h00);
      send_byte(8'h12);
      chk("pay_12", data_out_c, 8'h12);
      chk("pay_12_valid", {7'd0, valid_out_c}, 8'h01);
      send_byte(BC);
      chk("idle_comma_data", data_out_c, 8'h00);
      chk("idle_comma_valid", {7'd0, valid_out_c}, 8'h00);
      send_byte(8'hA5);
      chk("pay_a5", data_out_c, 8'hA5);
      // Shifted boundary after junk bits.
      do_reset();
      send_bits(8'h05, 3);
      for (int i = 0; i < 5; i++) send_byte(BC);
      send_byte(8'h3C);
      chk("shift_3c", data_out_c, 8'h3C);
      chk("shift_3c_valid", {7'd0, valid_out_c}, 8'h01);
      // Broken comma run falls back to hunting.
      do_reset();
      send_byte(BC);
      send_byte(BC);
      send_byte(8'h00);
      for (int i = 0; i < 3; i++) send_byte(BC);
      chk("broken_not_active", {7'd0, active_out}, 8'h00);
      send_byte(BC);
      chk("broken_relock", {7'd0, active_out}, 8'h01);
      // Mid-byte reset while active.
      send_bits(8'hE0, 3);
      tick(1'b1, 1'b1);
      n_edge = 0;
      chk("midrst_active", {7'd0, active_out}, 8'h00);
      chk("midrst_data", data_out_c, 8'h00);
      for (int i = 0; i < 4; i++) send_byte(BC);
      chk("midrst_relock", {7'd0, active_out}, 8'h01);
      // Comma bit pattern straddling two payload bytes.
      send_byte(8'h0B);
      chk("straddle_0b", data_out_c, 8'h0B);
      send_byte(8'hC0);
      chk("straddle_c0", data_out_c, 8'hC0);
      chk("straddle_valid", {7'd0, valid_out_c}, 8'h01);
      // Random payload mixed with idle commas.
      for (int i = 0; i < 60; i++) begin
         rb = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
         send_byte(rb);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
